// File: rtl/e_mdu_ctrl_if.sv
// Bundle between the E stage and the multiply/divide sequencer.
// The hazard-unit request and the architectural HI/LO are carried alongside the operands.
interface e_mdu_ctrl_if;
    logic [3:0]  mdOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        req;
    logic        d_mdUse;
    logic        busy;
    logic        stall_md;
    logic [31:0] mdResult;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output mdOp, srcA, srcB, req, d_mdUse,
        input  busy, stall_md, mdResult, hi, lo
    );

    modport slave (
        input  mdOp, srcA, srcB, req, d_mdUse,
        output busy, stall_md, mdResult, hi, lo
    );
endinterface

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: computes the result at launch and then holds
// it for a fixed busy latency before committing it to HI/LO.
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset,
    e_mdu_ctrl_if.slave   mdu
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, RUN} stateT;

    stateT             state;
    logic [CNT_W-1:0]  cnt;
    logic              busyReg;
    logic [31:0]       hiReg;
    logic [31:0]       loReg;
    logic [31:0]       tmpHi;
    logic [31:0]       tmpLo;
    logic              divZero;

    logic              isMulDiv;
    logic              launch;
    logic [63:0]       prodS;
    logic [63:0]       prodU;
    logic [31:0]       divisorU;
    logic [31:0]       absA;
    logic [31:0]       absB;
    logic [31:0]       qMag;
    logic [31:0]       rMag;
    logic [31:0]       resHi;
    logic [31:0]       resLo;
    logic [CNT_W-1:0]  loadCnt;

    // Signed division works on magnitudes so that MIN / -1 simply wraps.
    always_comb begin
        isMulDiv = (mdu.mdOp >= OP_MULT) && (mdu.mdOp <= OP_DIVU);
        launch   = isMulDiv && !busyReg && !mdu.req;

        prodS    = {{32{mdu.srcA[31]}}, mdu.srcA} * {{32{mdu.srcB[31]}}, mdu.srcB};
        prodU    = {32'd0, mdu.srcA} * {32'd0, mdu.srcB};

        divisorU = (mdu.srcB == 32'd0) ? 32'd1 : mdu.srcB;
        absA     = mdu.srcA[31] ? (~mdu.srcA + 32'd1) : mdu.srcA;
        absB     = mdu.srcB[31] ? (~mdu.srcB + 32'd1) : divisorU;
        qMag     = absA / absB;
        rMag     = absA % absB;

        resHi    = 32'd0;
        resLo    = 32'd0;
        loadCnt  = CNT_W'(MULT_CYCLES);
        case (mdu.mdOp)
            OP_MULT: begin
                resHi = prodS[63:32];
                resLo = prodS[31:0];
            end
            OP_MULTU: begin
                resHi = prodU[63:32];
                resLo = prodU[31:0];
            end
            OP_DIV: begin
                resLo   = (mdu.srcA[31] ^ mdu.srcB[31]) ? (~qMag + 32'd1) : qMag;
                resHi   = mdu.srcA[31] ? (~rMag + 32'd1) : rMag;
                loadCnt = CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
                resLo   = mdu.srcA / divisorU;
                resHi   = mdu.srcA % divisorU;
                loadCnt = CNT_W'(DIV_CYCLES);
            end
            default: begin
                resHi = 32'd0;
                resLo = 32'd0;
            end
        endcase
    end

    // A running op ignores new E-stage requests and the flush; it always commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busyReg <= 1'b0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            tmpHi   <= 32'd0;
            tmpLo   <= 32'd0;
            divZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state   <= RUN;
                        cnt     <= loadCnt;
                        busyReg <= 1'b1;
                        tmpHi   <= resHi;
                        tmpLo   <= resLo;
                        divZero <= (mdu.mdOp == OP_DIV || mdu.mdOp == OP_DIVU)
                                   && (mdu.srcB == 32'd0);
                    end else if (!mdu.req && mdu.mdOp == OP_MTHI) begin
                        hiReg <= mdu.srcA;
                    end else if (!mdu.req && mdu.mdOp == OP_MTLO) begin
                        loReg <= mdu.srcA;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        busyReg <= 1'b0;
                        if (!divZero) begin
                            hiReg <= tmpHi;
                            loReg <= tmpLo;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    // The stall also covers the launch cycle, before busy has risen.
    assign mdu.stall_md = mdu.d_mdUse && (busyReg || isMulDiv);
    assign mdu.mdResult = (mdu.mdOp == OP_MFHI) ? hiReg :
                          (mdu.mdOp == OP_MFLO) ? loReg : 32'd0;
    assign mdu.busy     = busyReg;
    assign mdu.hi       = hiReg;
    assign mdu.lo       = loReg;
endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Bench for e_mdu_ctrl: directed cases with literal expectations, then random traffic
// compared every cycle against a completion-time model of HI/LO.
module tb_e_mdu_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;

    e_mdu_ctrl_if mduBus ();

    e_mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mduBus)
    );

    always #5 clk = ~clk;

    int   nChecks = 0;
    int   nPass   = 0;
    bit   compareEn = 1'b0;

    bit          mBusy = 1'b0;
    int          mDoneEdge = 0;
    int          edgeIdx = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    logic [31:0] mPendHi = 32'd0;
    logic [31:0] mPendLo = 32'd0;
    bit          mPendWrite = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Architectural meaning of each op, written with wide integer arithmetic.
    function automatic void mduMath(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rHi, output logic [31:0] rLo, output bit write);
        longint          p;
        longint unsigned pu;
        longint          q;
        longint          r;
        write = 1'b1;
        rHi   = 32'd0;
        rLo   = 32'd0;
        case (op)
            4'd1: begin
                p   = longint'($signed(a)) * longint'($signed(b));
                rHi = p[63:32];
                rLo = p[31:0];
            end
            4'd2: begin
                pu  = longint'(a) * longint'(b);
                rHi = pu[63:32];
                rLo = pu[31:0];
            end
            4'd3: begin
                if (b == 32'd0) write = 1'b0;
                else begin
                    q   = longint'($signed(a)) / longint'($signed(b));
                    r   = longint'($signed(a)) % longint'($signed(b));
                    rLo = q[31:0];
                    rHi = r[31:0];
                end
            end
            4'd4: begin
                if (b == 32'd0) write = 1'b0;
                else begin
                    rLo = a / b;
                    rHi = a % b;
                end
            end
            default: write = 1'b0;
        endcase
    endfunction

    // Model: an op launched at edge k commits at edge k+N.
    initial forever begin
        @(posedge clk);
        edgeIdx++;
        if (reset) begin
            mBusy = 1'b0;
            mHi   = 32'd0;
            mLo   = 32'd0;
        end else if (mBusy) begin
            if (edgeIdx == mDoneEdge) begin
                mBusy = 1'b0;
                if (mPendWrite) begin
                    mHi = mPendHi;
                    mLo = mPendLo;
                end
            end
        end else if (!mduBus.req) begin
            if (mduBus.mdOp >= 4'd1 && mduBus.mdOp <= 4'd4) begin
                mduMath(mduBus.mdOp, mduBus.srcA, mduBus.srcB, mPendHi, mPendLo, mPendWrite);
                mBusy     = 1'b1;
                mDoneEdge = edgeIdx + ((mduBus.mdOp <= 4'd2) ? MULT_N : DIV_N);
            end else if (mduBus.mdOp == 4'd5) begin
                mHi = mduBus.srcA;
            end else if (mduBus.mdOp == 4'd6) begin
                mLo = mduBus.srcA;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (compareEn) begin
            logic [31:0] expRes;
            bit          expStall;
            expStall = mduBus.d_mdUse && (mBusy || (mduBus.mdOp >= 4'd1 && mduBus.mdOp <= 4'd4));
            expRes   = (mduBus.mdOp == 4'd7) ? mHi : (mduBus.mdOp == 4'd8) ? mLo : 32'd0;
            checkOutput("busy", 32'(mduBus.busy), 32'(mBusy));
            checkOutput("stall_md", 32'(mduBus.stall_md), 32'(expStall));
            checkOutput("mdResult", mduBus.mdResult, expRes);
            checkOutput("hi", mduBus.hi, mHi);
            checkOutput("lo", mduBus.lo, mLo);
        end
    end

    task automatic applyStimulus(input logic rst, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic rq, input logic du);
        @(posedge clk);
        #2;
        reset          = rst;
        mduBus.mdOp    = op;
        mduBus.srcA    = a;
        mduBus.srcB    = b;
        mduBus.req     = rq;
        mduBus.d_mdUse = du;
        #1;
    endtask

    task automatic idleCount(input int n, input logic du, output int busyCnt, output int stallCnt);
        busyCnt  = 0;
        stallCnt = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, du);
            busyCnt  += int'(mduBus.busy);
            stallCnt += int'(mduBus.stall_md);
        end
    endtask

    initial begin
        int busyCnt;
        int stallCnt;
        int launchStall;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int r;

        reset          = 1'b1;
        mduBus.mdOp    = 4'd0;
        mduBus.srcA    = 32'd0;
        mduBus.srcB    = 32'd0;
        mduBus.req     = 1'b0;
        mduBus.d_mdUse = 1'b0;
        @(posedge clk);
        #2;
        compareEn = 1'b1;
        applyStimulus(1'b1, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("reset busy", 32'(mduBus.busy), 32'd0);
        checkOutput("reset hi", mduBus.hi, 32'd0);
        checkOutput("reset lo", mduBus.lo, 32'd0);

        // mult -2*3 with a dependent D-stage op waiting
        applyStimulus(1'b0, 4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1);
        launchStall = int'(mduBus.stall_md);
        idleCount(12, 1'b1, busyCnt, stallCnt);
        checkOutput("mult busy cycles", 32'(busyCnt), 32'd5);
        checkOutput("mult stall cycles", 32'(stallCnt + launchStall), 32'd6);
        checkOutput("mult hi", mduBus.hi, 32'hFFFFFFFF);
        checkOutput("mult lo", mduBus.lo, 32'hFFFFFFFA);
        applyStimulus(1'b0, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("mfhi after mult", mduBus.mdResult, 32'hFFFFFFFF);

        applyStimulus(1'b0, 4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        launchStall = int'(mduBus.stall_md);
        idleCount(12, 1'b0, busyCnt, stallCnt);
        checkOutput("multu stall without d_mdUse", 32'(stallCnt + launchStall), 32'd0);
        checkOutput("multu hi", mduBus.hi, 32'h00000002);
        checkOutput("multu lo", mduBus.lo, 32'hFFFFFFFA);

        applyStimulus(1'b0, 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        idleCount(14, 1'b0, busyCnt, stallCnt);
        checkOutput("div busy cycles", 32'(busyCnt), 32'd10);
        checkOutput("div lo", mduBus.lo, 32'hFFFFFFFD);
        checkOutput("div hi", mduBus.hi, 32'hFFFFFFFF);

        applyStimulus(1'b0, 4'd4, 32'd7, 32'd2, 1'b0, 1'b0);
        idleCount(12, 1'b0, busyCnt, stallCnt);
        checkOutput("divu lo", mduBus.lo, 32'd3);
        checkOutput("divu hi", mduBus.hi, 32'd1);

        applyStimulus(1'b0, 4'd5, 32'h11, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd6, 32'h22, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd4, 32'd5, 32'd0, 1'b0, 1'b0);
        idleCount(14, 1'b0, busyCnt, stallCnt);
        checkOutput("divzero busy cycles", 32'(busyCnt), 32'd10);
        checkOutput("divzero hi kept", mduBus.hi, 32'h11);
        checkOutput("divzero lo kept", mduBus.lo, 32'h22);

        applyStimulus(1'b0, 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        idleCount(12, 1'b0, busyCnt, stallCnt);
        checkOutput("min div lo", mduBus.lo, 32'h80000000);
        checkOutput("min div hi", mduBus.hi, 32'd0);

        applyStimulus(1'b0, 4'd1, 32'd5, 32'd6, 1'b1, 1'b0);
        idleCount(8, 1'b0, busyCnt, stallCnt);
        checkOutput("flushed busy cycles", 32'(busyCnt), 32'd0);
        checkOutput("flushed lo kept", mduBus.lo, 32'h80000000);

        // flush and stray ops while running must not disturb the in-flight mult
        applyStimulus(1'b0, 4'd1, 32'd5, 32'd6, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd5, 32'hDEAD, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        idleCount(14, 1'b0, busyCnt, stallCnt);
        checkOutput("req during run lo", mduBus.lo, 32'd30);
        checkOutput("req during run hi", mduBus.hi, 32'd0);

        applyStimulus(1'b0, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        idleCount(3, 1'b0, busyCnt, stallCnt);
        applyStimulus(1'b1, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("midop reset busy", 32'(mduBus.busy), 32'd0);
        idleCount(15, 1'b0, busyCnt, stallCnt);
        checkOutput("midop reset later busy", 32'(busyCnt), 32'd0);
        checkOutput("midop reset hi", mduBus.hi, 32'd0);
        checkOutput("midop reset lo", mduBus.lo, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if      (r < 8)  op = 4'd1;
            else if (r < 16) op = 4'd2;
            else if (r < 22) op = 4'd3;
            else if (r < 28) op = 4'd4;
            else if (r < 36) op = 4'd5;
            else if (r < 44) op = 4'd6;
            else if (r < 54) op = 4'd7;
            else if (r < 64) op = 4'd8;
            else if (r < 68) op = 4'($urandom_range(9, 15));
            else             op = 4'd0;
            a = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            applyStimulus(($urandom_range(0, 399) == 0), op, a, b,
                          ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end
        idleCount(12, 1'b0, busyCnt, stallCnt);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Execute-stage multiply/divide sequencer. Sits beside the E-stage ALU in the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage and models the multi-cycle latency with a busy counter.
- Commits results to architectural HI/LO registers and raises a stall request to the hazard unit while a D-stage MDU instruction must wait.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
mdOp  input  4  E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others = none
srcA  input  32  rs operand (forwarded)
srcB  input  32  rt operand (forwarded)
req  input  1  exception/interrupt flush of the E-stage instruction; suppresses its effect
d_mdUse  input  1  D-stage instruction is any MDU op (1..8)
busy  output  1  multi-cycle op in flight
stall_md  output  1  stall request to hazard unit
mdResult  output  32  HI for mfhi, LO for mflo, else 0
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, reset). Reset has priority over every other input on the same edge.
- Reset values: busy=0, cnt=0, hi=0, lo=0, tmp_hi=0, tmp_lo=0. stall_md and mdResult follow from these combinationally.
- States:
  - IDLE (cnt==0, busy=0)
  - RUN (cnt>0, busy=1)
- launch = (mdOp in 1..4) & ~busy & ~req.
- IDLE->RUN on launch edge:
  - cnt <= MULT_CYCLES or DIV_CYCLES; busy <= 1.
  - Result computed from srcA/srcB at launch and latched into tmp_hi/tmp_lo.
- Arithmetic:
  - mult: signed 32x32->64 product; tmp_hi=[63:32], tmp_lo=[31:0]. multu: unsigned 32x32->64 product, same split.
  - div: signed; tmp_lo=quotient, tmp_hi=remainder (remainder takes dividend sign, quotient truncates toward zero).
  - divu: unsigned, same split.
  - srcB==0 for div/divu: op still runs full DIV_CYCLES, but hi/lo are NOT updated at completion (flag latched at launch).
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no exception).
- RUN: cnt decrements each edge. On the edge where cnt==1: cnt<=0, busy<=0, hi<=tmp_hi, lo<=tmp_lo (unless div-zero flag). Result is visible the cycle busy falls.
- Latency: launch edge + N busy cycles. busy is high for exactly N cycles; hi/lo are valid from cycle N+1 after launch.
- mthi/mtlo:
  - Single-cycle. hi<=srcA (mthi) or lo<=srcA (mtlo) on the edge when ~busy & ~req.
  - If busy, the write is ignored; the hazard unit never issues one there.
- mfhi/mflo: mdResult is combinational from current hi/lo. No forwarding of in-flight tmp values.
- Ops while busy: a second mult/div or mt* in E while busy is ignored (no restart, no counter reload). This is a defensive case only.
- req:
  - req=1 cancels the E-stage op: no launch, no mt* write.
  - An op already in RUN is NOT cancelled; it completes and commits (architecturally committed at launch).
- stall_md = d_mdUse & (busy | (mdOp in 1..4)). The stall covers the launch cycle too, before busy rises.
- Reset mid-operation: busy, cnt, hi, lo clear on the next edge; the pending result is discarded.

Test Plan:
- mult launch: srcA=0xFFFFFFFE (-2), srcB=3, mdOp=1 for 1 cycle. Required: busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- div signed: srcA=-7 (0xFFFFFFF9), srcB=2, mdOp=3. Required: busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 7/2 gives lo=3, hi=1.
- Div by zero: preload hi=0x11, lo=0x22 via mthi/mtlo; divu srcA=5, srcB=0. Required: busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- Stall/hazard: d_mdUse=1 during the launch cycle and busy cycles -> stall_md=1 for 1+5 cycles on mult; stall_md=0 with d_mdUse=0; mfhi after busy falls returns the new HI.
- req flush: mdOp=1 with req=1 -> busy stays 0, hi/lo unchanged. req=1 while RUN -> op still completes and commits.
- Reset mid-op: reset asserted 3 cycles into a div -> next edge busy=0, hi=lo=0, and no later commit occurs.
